// File: rtl/wnd_spill_fill_unit.sv
// Register-window spill/fill engine: moves one O-register window between a
// warp's vector-register partition and that warp's memory stack, one register
// at a time, over a single-outstanding valid/ready memory port.
module wnd_spill_fill_unit #(
  parameter int unsigned N                     = 8,
  parameter int unsigned W                     = 2,
  parameter int unsigned O                     = 20,
  parameter int unsigned DEPTH                 = 4,
  parameter int unsigned DATA_W                = 32,
  parameter int unsigned ADDR_W                = 32,
  parameter logic [ADDR_W-1:0] SPILL_BASE      = 32'h0000_F000
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_fill,
  input  logic [W-1:0]      req_wid,
  input  logic [N-W-1:0]    req_base,
  output logic              rf_rd_en,
  output logic [N-1:0]      rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_wr_en,
  output logic [N-1:0]      rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_data,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              done_valid,
  output logic [W-1:0]      done_wid,
  output logic              done_err,
  output logic              busy
);

  localparam int unsigned RW    = N - W;
  localparam int unsigned NW    = 1 << W;
  localparam int unsigned IW    = (O > 1) ? $clog2(O) : 1;
  localparam int unsigned SPW   = $clog2(DEPTH + 1);
  localparam int unsigned SHIFT = $clog2(DATA_W / 8);

  typedef enum logic [3:0] {
    IDLE, CHK, SP_RD, SP_WAIT, SP_MEM, FL_REQ, FL_RSP, FL_WR, DONE
  } state_t;

  state_t                   state_q, state_d;
  logic                     fill_q, fill_d;
  logic [W-1:0]             wid_q, wid_d;
  logic [RW-1:0]            base_q, base_d;
  logic [IW-1:0]            i_q, i_d;
  logic                     err_q, err_d;
  logic [DATA_W-1:0]        data_q, data_d;
  logic [NW-1:0][SPW-1:0]   sp_q, sp_d;

  logic                     req_ready_q, busy_q, rf_rd_en_q, rf_wr_en_q;
  logic                     mem_req_valid_q, mem_req_rw_q;
  logic                     done_valid_q, done_err_q;
  logic [W-1:0]             done_wid_q;
  logic [N-1:0]             rf_addr_q;
  logic [ADDR_W-1:0]        mem_addr_q;

  logic                     last_c;
  logic [SPW-1:0]           sp_cur_c;
  logic [SPW-1:0]           slot_c;
  logic [ADDR_W-1:0]        lin_c;
  logic [ADDR_W-1:0]        mem_addr_c;
  logic [N-1:0]             rf_addr_c;

  assign last_c   = (i_q == IW'(O - 1));
  assign sp_cur_c = sp_q[wid_q];

  // Next-state, index and stack-pointer update.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    wid_d   = wid_q;
    base_d  = base_q;
    i_d     = i_q;
    err_d   = err_q;
    data_d  = data_q;
    sp_d    = sp_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          fill_d  = req_fill;
          wid_d   = req_wid;
          base_d  = req_base;
          i_d     = '0;
          err_d   = 1'b0;
          state_d = CHK;
        end
      end
      CHK: begin
        if (fill_q ? (sp_cur_c == '0) : (sp_cur_c == SPW'(DEPTH))) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = fill_q ? FL_REQ : SP_RD;
        end
      end
      SP_RD:   state_d = SP_WAIT;
      SP_WAIT: begin
        data_d  = rf_rd_data;
        state_d = SP_MEM;
      end
      SP_MEM: begin
        if (mem_req_ready) begin
          if (last_c) begin
            sp_d[wid_q] = sp_cur_c + SPW'(1);
            state_d     = DONE;
          end else begin
            i_d     = i_q + IW'(1);
            state_d = SP_RD;
          end
        end
      end
      FL_REQ: begin
        if (mem_req_ready) state_d = FL_RSP;
      end
      FL_RSP: begin
        if (mem_rsp_valid) begin
          data_d  = mem_rsp_data;
          state_d = FL_WR;
        end
      end
      FL_WR: begin
        if (last_c) begin
          sp_d[wid_q] = sp_cur_c - SPW'(1);
          state_d     = DONE;
        end else begin
          i_d     = i_q + IW'(1);
          state_d = FL_REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Addresses for the register the next state works on; fill pops the top slot.
  always_comb begin
    slot_c     = fill_d ? (sp_q[wid_d] - SPW'(1)) : sp_q[wid_d];
    lin_c      = (ADDR_W'(wid_d) * ADDR_W'(DEPTH) + ADDR_W'(slot_c)) * ADDR_W'(O)
                 + ADDR_W'(i_d);
    mem_addr_c = SPILL_BASE + (lin_c << SHIFT);
    rf_addr_c  = {wid_d, base_d + RW'(i_d)};
  end

  // Control state, transfer data and per-warp stack pointers.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state_q <= IDLE;
      fill_q  <= 1'b0;
      wid_q   <= '0;
      base_q  <= '0;
      i_q     <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      wid_q   <= wid_d;
      base_q  <= base_d;
      i_q     <= i_d;
      err_q   <= err_d;
      data_q  <= data_d;
      sp_q    <= sp_d;
    end
  end

  // Output registers decoded from the next state so strobes align with it.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      req_ready_q     <= 1'b1;
      busy_q          <= 1'b0;
      rf_rd_en_q      <= 1'b0;
      rf_wr_en_q      <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_rw_q    <= 1'b0;
      done_valid_q    <= 1'b0;
      done_err_q      <= 1'b0;
      done_wid_q      <= '0;
      rf_addr_q       <= '0;
      mem_addr_q      <= '0;
    end else begin
      req_ready_q     <= (state_d == IDLE);
      busy_q          <= (state_d != IDLE);
      rf_rd_en_q      <= (state_d == SP_RD);
      rf_wr_en_q      <= (state_d == FL_WR);
      mem_req_valid_q <= (state_d == SP_MEM) || (state_d == FL_REQ);
      mem_req_rw_q    <= (state_d == SP_MEM);
      done_valid_q    <= (state_d == DONE);
      done_err_q      <= (state_d == DONE) && err_d;
      done_wid_q      <= wid_d;
      rf_addr_q       <= rf_addr_c;
      mem_addr_q      <= mem_addr_c;
    end
  end

  assign req_ready     = req_ready_q;
  assign busy          = busy_q;
  assign rf_rd_en      = rf_rd_en_q;
  assign rf_rd_addr    = rf_addr_q;
  assign rf_wr_en      = rf_wr_en_q;
  assign rf_wr_addr    = rf_addr_q;
  assign rf_wr_data    = data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_rw    = mem_req_rw_q;
  assign mem_req_addr  = mem_addr_q;
  assign mem_req_data  = data_q;
  assign done_valid    = done_valid_q;
  assign done_wid      = done_wid_q;
  assign done_err      = done_err_q;

endmodule

// File: tb/tb_wnd_spill_fill_unit.sv
// Directed bench for wnd_spill_fill_unit with a register-file and memory model.
module tb_wnd_spill_fill_unit;

  localparam logic [31:0] BASE = 32'h0000_F000;

  logic        clk = 1'b0;
  logic        nRST = 1'b0;
  logic        req_valid = 1'b0, req_fill = 1'b0;
  logic [1:0]  req_wid = '0;
  logic [5:0]  req_base = '0;
  logic        req_ready, rf_rd_en, rf_wr_en, mem_req_valid, mem_req_rw;
  logic [7:0]  rf_rd_addr, rf_wr_addr;
  logic [31:0] rf_rd_data = '0, rf_wr_data, mem_req_addr, mem_req_data;
  logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        done_valid, done_err, busy;
  logic [1:0]  done_wid;

  always #5 clk = ~clk;

  wnd_spill_fill_unit dut (
    .clk(clk), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_fill(req_fill),
    .req_wid(req_wid), .req_base(req_base),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .done_valid(done_valid), .done_wid(done_wid), .done_err(done_err), .busy(busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [7:0] a);
    return 32'h3C00_0000 + {16'h0, a, a};
  endfunction

  function automatic logic [31:0] maddr(input int wid, input int slot, input int i);
    return BASE + (32'((wid * 4 + slot) * 20 + i) << 2);
  endfunction

  // Register file: read data valid the cycle after the strobe.
  always @(posedge clk) if (rf_rd_en) rf_rd_data <= pat(rf_rd_addr);

  // Transaction logs.
  logic [31:0] mq_addr[$], mq_data[$], rd_q[$], wa_q[$], wd_q[$];
  logic        mq_rw[$];
  int          done_cnt = 0;
  always @(posedge clk) begin
    if (mem_req_valid && mem_req_ready) begin
      mq_addr.push_back(mem_req_addr);
      mq_data.push_back(mem_req_data);
      mq_rw.push_back(mem_req_rw);
    end
    if (rf_rd_en) rd_q.push_back(32'(rf_rd_addr));
    if (rf_wr_en) begin
      wa_q.push_back(32'(rf_wr_addr));
      wd_q.push_back(rf_wr_data);
    end
    if (done_valid) done_cnt <= done_cnt + 1;
  end

  // Memory model: spill stack storage, random ready, delayed read responses.
  logic        rnd_mode = 1'b0;
  int          dly_max = 0;
  logic [31:0] mem [320];
  logic [31:0] m_ofs;
  logic        m_ok;
  logic        rsp_pend = 1'b0;
  int          rsp_wait = 0;
  logic [31:0] rsp_buf = '0;
  assign m_ofs = (mem_req_addr - BASE) >> 2;
  assign m_ok  = (m_ofs < 32'd320);

  always @(posedge clk) mem_req_ready <= rnd_mode ? 1'($urandom_range(1, 0)) : 1'b1;

  always @(posedge clk) begin
    mem_rsp_valid <= 1'b0;
    if (mem_req_valid && mem_req_ready) begin
      if (mem_req_rw) begin
        if (m_ok) mem[m_ofs[8:0]] <= mem_req_data;
      end else if (dly_max == 0 || $urandom_range(3, 0) == 0) begin
        mem_rsp_valid <= 1'b1;
        mem_rsp_data  <= m_ok ? mem[m_ofs[8:0]] : 32'h0;
      end else begin
        rsp_pend <= 1'b1;
        rsp_wait <= int'($urandom_range(dly_max - 1, 0));
        rsp_buf  <= m_ok ? mem[m_ofs[8:0]] : 32'h0;
      end
    end else if (rsp_pend) begin
      if (rsp_wait == 0) begin
        mem_rsp_valid <= 1'b1;
        mem_rsp_data  <= rsp_buf;
        rsp_pend      <= 1'b0;
      end else begin
        rsp_wait <= rsp_wait - 1;
      end
    end
  end

  // Request hold-stability and register-file strobe exclusivity.
  logic        rst_edge = 1'b1;
  logic        pv = 1'b0, pr = 1'b0, prw = 1'b0;
  logic [31:0] pa = '0, pd = '0;
  always @(posedge clk) rst_edge <= !nRST;
  always @(negedge clk) begin
    if (!rst_edge && pv && !pr) begin
      chk("hold_valid", 32'(mem_req_valid), 32'd1);
      chk("hold_addr", mem_req_addr, pa);
      chk("hold_rw", 32'(mem_req_rw), 32'(prw));
      if (prw) chk("hold_data", mem_req_data, pd);
    end
    if (rf_rd_en || rf_wr_en) chk("rf_excl", 32'(rf_rd_en & rf_wr_en), 32'd0);
    pv  <= mem_req_valid;
    pr  <= mem_req_ready;
    pa  <= mem_req_addr;
    pd  <= mem_req_data;
    prw <= mem_req_rw;
  end

  int          last_cyc;
  logic        last_err;
  int          m0, r0, w0;

  task automatic run_req(input logic fill, input logic [1:0] wid, input logic [5:0] base);
    int cyc;
    m0 = mq_addr.size();
    r0 = rd_q.size();
    w0 = wa_q.size();
    @(negedge clk);
    req_valid = 1'b1; req_fill = fill; req_wid = wid; req_base = base;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!done_valid && cyc < 3000) begin
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", 32'(done_valid), 32'd1);
    chk("done_wid", 32'(done_wid), 32'(wid));
    last_cyc = cyc;
    last_err = done_err;
    @(negedge clk);
    chk("done_pulse", 32'(done_valid), 32'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rf_rd_en"}, 32'(rf_rd_en), 32'd0);
    chk({tag, "_rf_wr_en"}, 32'(rf_wr_en), 32'd0);
    chk({tag, "_mem_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_mem_rw"}, 32'(mem_req_rw), 32'd0);
    chk({tag, "_mem_addr"}, mem_req_addr, 32'd0);
    chk({tag, "_mem_data"}, mem_req_data, 32'd0);
    chk({tag, "_rf_addr"}, 32'(rf_rd_addr), 32'd0);
    chk({tag, "_done"}, 32'(done_valid), 32'd0);
    chk({tag, "_done_err"}, 32'(done_err), 32'd0);
    chk({tag, "_done_wid"}, 32'(done_wid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, dc0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    nRST = 1'b1;

    // Spill warp 1, base 0.
    run_req(1'b0, 2'd1, 6'd0);
    chk("sp1_lat", 32'(last_cyc), 32'd62);
    chk("sp1_err", 32'(last_err), 32'd0);
    chk("sp1_cnt", 32'(mq_addr.size() - m0), 32'd20);
    for (int i = 0; i < 20; i++) begin
      chk("sp1_addr", mq_addr[m0 + i], maddr(1, 0, i));
      chk("sp1_data", mq_data[m0 + i], pat(8'(64 + i)));
      chk("sp1_rw", 32'(mq_rw[m0 + i]), 32'd1);
      chk("sp1_rfa", rd_q[r0 + i], 32'(64 + i));
    end

    // Fill it back into base 5.
    run_req(1'b1, 2'd1, 6'd5);
    chk("fl1_lat", 32'(last_cyc), 32'd62);
    chk("fl1_err", 32'(last_err), 32'd0);
    chk("fl1_cnt", 32'(mq_addr.size() - m0), 32'd20);
    chk("fl1_wcnt", 32'(wa_q.size() - w0), 32'd20);
    for (int i = 0; i < 20; i++) begin
      chk("fl1_addr", mq_addr[m0 + i], maddr(1, 0, i));
      chk("fl1_rw", 32'(mq_rw[m0 + i]), 32'd0);
      chk("fl1_wa", wa_q[w0 + i], 32'(69 + i));
      chk("fl1_wd", wd_q[w0 + i], pat(8'(64 + i)));
    end

    // Underflow: warp 1 is back to empty, warp 2 never used.
    run_req(1'b1, 2'd1, 6'd0);
    chk("uf1_err", 32'(last_err), 32'd1);
    run_req(1'b1, 2'd2, 6'd0);
    chk("uf2_err", 32'(last_err), 32'd1);
    chk("uf2_lat", 32'(last_cyc), 32'd2);
    chk("uf2_mem", 32'(mq_addr.size() - m0), 32'd0);
    chk("uf2_rd", 32'(rd_q.size() - r0), 32'd0);
    chk("uf2_wr", 32'(wa_q.size() - w0), 32'd0);

    // Fill warp 0's stack, then overflow it.
    for (int k = 0; k < 4; k++) begin
      run_req(1'b0, 2'd0, 6'(k * 3));
      chk("sp0_lat", 32'(last_cyc), 32'd62);
      chk("sp0_err", 32'(last_err), 32'd0);
      chk("sp0_addr0", mq_addr[m0], maddr(0, k, 0));
      chk("sp0_addr19", mq_addr[m0 + 19], maddr(0, k, 19));
      chk("sp0_data0", mq_data[m0], pat(8'(k * 3)));
    end
    run_req(1'b0, 2'd0, 6'd0);
    chk("of_err", 32'(last_err), 32'd1);
    chk("of_lat", 32'(last_cyc), 32'd2);
    chk("of_mem", 32'(mq_addr.size() - m0), 32'd0);
    chk("of_rd", 32'(rd_q.size() - r0), 32'd0);
    run_req(1'b1, 2'd0, 6'd40);
    chk("of_fill_err", 32'(last_err), 32'd0);
    chk("of_fill_addr", mq_addr[m0], maddr(0, 3, 0));
    chk("of_fill_wa", wa_q[w0], 32'd40);
    chk("of_fill_wd", wd_q[w0], pat(8'd9));

    // Register index wraps inside warp 2's partition.
    run_req(1'b0, 2'd2, 6'd60);
    chk("wrap_err", 32'(last_err), 32'd0);
    for (int i = 0; i < 20; i++) begin
      chk("wrap_rfa", rd_q[r0 + i], 32'(128 + ((60 + i) % 64)));
      chk("wrap_data", mq_data[m0 + i], pat(8'(128 + ((60 + i) % 64))));
    end

    // Random ready and delayed responses.
    rnd_mode = 1'b1;
    dly_max  = 5;
    run_req(1'b0, 2'd3, 6'd10);
    chk("rnd_sp_err", 32'(last_err), 32'd0);
    chk("rnd_sp_cnt", 32'(mq_addr.size() - m0), 32'd20);
    for (int i = 0; i < 20; i++) begin
      chk("rnd_sp_addr", mq_addr[m0 + i], maddr(3, 0, i));
      chk("rnd_sp_data", mq_data[m0 + i], pat(8'(202 + i)));
    end
    run_req(1'b1, 2'd3, 6'd30);
    chk("rnd_fl_err", 32'(last_err), 32'd0);
    chk("rnd_fl_cnt", 32'(mq_addr.size() - m0), 32'd20);
    chk("rnd_fl_wcnt", 32'(wa_q.size() - w0), 32'd20);
    for (int i = 0; i < 20; i++) begin
      chk("rnd_fl_addr", mq_addr[m0 + i], maddr(3, 0, i));
      chk("rnd_fl_wa", wa_q[w0 + i], 32'(222 + i));
      chk("rnd_fl_wd", wd_q[w0 + i], pat(8'(202 + i)));
    end
    rnd_mode = 1'b0;
    dly_max  = 0;
    repeat (3) @(negedge clk);

    // Reset while the 7th register of a spill is in flight.
    r0  = rd_q.size();
    dc0 = done_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_fill = 1'b0; req_wid = 2'd1; req_base = 6'd0;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (rd_q.size() < r0 + 7 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reach7", 32'(rd_q.size() - r0), 32'd7);
    nRST = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midrst");
    nRST = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt - dc0), 32'd0);

    // Stack pointers cleared: warp 0 empty again, new spill lands in slot 0.
    run_req(1'b1, 2'd0, 6'd0);
    chk("rst_sp0_empty", 32'(last_err), 32'd1);
    run_req(1'b0, 2'd0, 6'd0);
    chk("rst_sp_lat", 32'(last_cyc), 32'd62);
    chk("rst_sp_err", 32'(last_err), 32'd0);
    chk("rst_sp_addr0", mq_addr[m0], maddr(0, 0, 0));
    chk("rst_sp_data5", mq_data[m0 + 5], pat(8'd5));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
